sevenseg_scan_driver: RTL

- Downstream consumer of the Gray-to-binary stage. Takes the 4-bit binary value and drives a 4-digit, time-multiplexed, common-anode seven-segment display.
- Digit 3 shows the hex digit, digit 2 is blank, and digits 1..0 show the decimal value 00–15. The decimal tens digit is optionally blanked when zero.
- The input is snapshotted once per scan frame, so a value change never tears across digits.

---
 rtl/sevenseg_scan_driver.sv | 117 +++++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Shows hex on digit 3, blank on digit 2, and decimal 00-15 on digits 1..0, snapshotted once per frame.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bin_i,
  input  logic       en_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o,
  output logic       frame_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("sevenseg_scan_driver: REFRESH_DIV must be 2 or more");
  end

  // Active-high {g..a} glyph for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  endfunction

  logic [CNT_W-1:0] div_cnt_r;
  logic [1:0]       idx_r;
  logic [3:0]       snap_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             frame_r;

  logic       wrap_s;
  logic       boundary_s;
  logic       ge10_s;
  logic       blank_s;
  logic [3:0] digit_s;
  logic [6:0] glyph_s;

  // Scan timing and digit content decode from the current snapshot and digit index.
  always_comb begin
    wrap_s     = (div_cnt_r == CNT_LAST);
    boundary_s = wrap_s && (idx_r == 2'd3);
    ge10_s     = (snap_r >= 4'd10);
    digit_s    = 4'd0;
    blank_s    = 1'b0;
    case (idx_r)
      2'd0: digit_s = ge10_s ? (snap_r - 4'd10) : snap_r;
      2'd1: begin
        digit_s = {3'b000, ge10_s};
        blank_s = (BLANK_LZ != 0) && !ge10_s;
      end
      2'd2: blank_s = 1'b1;
      2'd3: digit_s = snap_r;
      default: blank_s = 1'b1;
    endcase
    glyph_s = blank_s ? 7'h00 : glyph(digit_s);
  end

  // Scan counters, per-frame snapshot, and the registered anode/segment pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      idx_r     <= 2'd0;
      snap_r    <= 4'd0;
      seg_r     <= 7'h7F;
      an_r      <= 4'hF;
      frame_r   <= 1'b0;
    end else begin
      // idx wraps 3 -> 0 on its own, which is exactly the frame boundary
      if (wrap_s) begin
        div_cnt_r <= '0;
        idx_r     <= idx_r + 2'd1;
      end else begin
        div_cnt_r <= div_cnt_r + CNT_W'(1);
      end
      if (boundary_s) begin
        snap_r <= bin_i;
      end
      frame_r <= boundary_s;
      if (en_i) begin
        an_r  <= ~(4'b0001 << idx_r);
        seg_r <= ~glyph_s;
      end else begin
        an_r  <= 4'hF;
        seg_r <= 7'h7F;
      end
    end
  end

  assign seg_o   = seg_r;
  assign an_o    = an_r;
  assign frame_o = frame_r;
  assign dp_o    = 1'b1;

endmodule
